// File: rtl/custom_switches.sv
// Avalon-MM switch/button input peripheral: synchronize, debounce,
// capture qualifying edges (W1C) and raise a maskable level interrupt.
module custom_switches #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       avs_s0_address,
    input  logic             avs_s0_read,
    output logic [31:0]      avs_s0_readdata,
    input  logic             avs_s0_write,
    input  logic [31:0]      avs_s0_writedata,
    input  logic [WIDTH-1:0] coe_sw_in,
    output logic             ins_irq
);

    localparam int ARM_MAX = DEBOUNCE_CYCLES + 2;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^avs_s0_writedata;

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign qual = rise | (fall & ~edge_sel);

    always_comb begin
        cap_clr = '0;
        if (avs_s0_write && avs_s0_address == 2'd1)
            cap_clr = avs_s0_writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (avs_s0_address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd1:    rd_mux[WIDTH-1:0] = capture;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            default: rd_mux[WIDTH-1:0] = edge_sel;
        endcase
    end

    // Synchronizer and per-bit saturating debounce counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            sync1    <= coe_sw_in;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Arm window hides the power-up edge of switches already high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            if (arm_cnt == ARM_W'(ARM_MAX))
                armed <= 1'b1;
            else
                arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture         <= '0;
            irq_mask        <= '0;
            edge_sel        <= '0;
            avs_s0_readdata <= '0;
            ins_irq         <= 1'b0;
        end else begin
            capture <= (capture & ~cap_clr) | (armed ? qual : '0);
            if (avs_s0_write && avs_s0_address == 2'd2)
                irq_mask <= avs_s0_writedata[WIDTH-1:0];
            if (avs_s0_write && avs_s0_address == 2'd3)
                edge_sel <= avs_s0_writedata[WIDTH-1:0];
            if (avs_s0_read)
                avs_s0_readdata <= rd_mux;
            ins_irq <= |(capture & irq_mask);
        end
    end

endmodule
